pio_debounce_irq_ctrl: RTL
==========================

Name: pio_debounce_irq_ctrl

Overview:
Controller for the switch input PIO. It samples in_port on a prescaled tick, debounces each bit, and captures edges into a sticky register. It raises a maskable level interrupt. Sits between the board switches and the Avalon-MM interconnect as a slave with read latency 1, replacing raw polling of the switch port.

Parameters:
WIDTH, 10, number of switch inputs
SAMPLE_DIV, 50000, clk cycles per sample tick (1 kHz at 50 MHz); legal range 2 to 2^20
STABLE_CNT, 4, consecutive differing ticks required to accept a new level; legal range 1 to 15

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  register select
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
writedata  in  32  write data
readdata  out  32  registered read data
in_port  in  WIDTH  raw switch inputs, asynchronous
irq  out  1  level interrupt, active high

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (reset_n). All flops clear on reset_n=0 regardless of clk.
- Reset values: readdata=0, irq=0, debounced=0, edge_cap=0, mask=0, ctrl=0, prescaler=0, per-bit counters=0, FSM=IDLE.
- in_port passes through a 2-flop synchronizer (sync). sync is not readable.
- Register map:
  - 0: debounced[WIDTH-1:0], read-only.
  - 1: mask, read/write.
  - 2: edge_cap; write 1 to a bit clears that bit.
  - 3: ctrl, read/write. bit0 = EN; bit1 = POL, 0 selects rising edges, 1 selects falling edges.
  - Unused bits read as 0. Writes to address 0 are ignored.
- readdata is registered every cycle from the address mux (zero-extended). Data is valid the cycle after read is asserted; the read strobe has no side effects.
- Prescaler counts 0 to SAMPLE_DIV-1 while EN=1. tick=1 in the cycle the count equals SAMPLE_DIV-1, then the count wraps to 0. When EN=0 the prescaler is held at 0.
- FSM:
  - IDLE: EN=0. Prescaler and counters held; debounced frozen. Transitions to PRIME when EN=1.
  - PRIME: on the first tick, debounced <= sync with no edge capture, then transitions to RUN. This suppresses false edges at power-up and re-enable.
  - RUN: per-bit debounce as below. EN=0 returns to IDLE and clears counters but keeps debounced and edge_cap.
- Per-bit debounce in RUN, on tick:
  - If sync != debounced: counter increments.
  - If the counter would reach STABLE_CNT: debounced toggles and the counter clears.
  - If sync == debounced: the counter clears.
  - With STABLE_CNT=1 the change is accepted on the first differing tick.
- Edge capture: a debounced transition matching POL sets edge_cap in the same cycle debounced updates.
- Simultaneous set and write-1-clear on the same bit in the same cycle: set wins.
- irq is registered as the OR-reduce of (edge_cap & mask), so it asserts one cycle after the edge_cap or mask change.
- Writing mask=0 deasserts irq next cycle without clearing edge_cap.

Optional Feature:
- Macro PIO_EVENT_COUNT_EN.
- Defined: a 16-bit saturating counter increments once per cycle in which any edge_cap bit is newly set. Several bits set in the same cycle count as one. It saturates at 0xFFFF and is readable at address 3 bits[31:16]. Any write to address 3 with writedata[31]=1 clears it. Reset value is 0.
- Undefined: address 3 bits[31:16] read 0, writedata[31] is ignored, and no counter logic is generated.

Decomposition:
- Package pio_ctrl_pkg holds:
  - register address constants ADDR_DATA, ADDR_MASK, ADDR_EDGE, ADDR_CTRL;
  - ctrl bit indices CTRL_EN, CTRL_POL;
  - FSM state enum {IDLE, PRIME, RUN};
  - event counter width (16).
- Sub-module pio_debounce_bit: one per bit, generated WIDTH times. Inputs are clk, reset_n, tick, run, prime and sync bit. It holds the stable counter and the debounced bit and outputs the level plus a one-cycle rise/fall pulse. The top level owns the prescaler, FSM, registers and irq.

Test Plan:
All scenarios use SAMPLE_DIV=4 and STABLE_CNT=3.
- Reset with in_port=0x3FF, then write ctrl=0x1. PRIME loads debounced=0x3FF on the first tick; edge_cap stays 0x000 and irq stays 0.
- In RUN, drop in_port to 0x3FE. debounced[0] goes to 0 exactly on the 3rd tick after sync changes. With ctrl=0x3 (falling), edge_cap=0x001.
- Toggle bit 1 for 2 ticks, then restore it. debounced is unchanged and edge_cap[1]=0 (glitch rejected, counter cleared).
- Capture a rising edge with mask=0x004 and edge_cap[2]=1: irq=1 one cycle later. Write 0x004 to address 2: irq=0 next cycle. Write 1-clear in the same cycle as a new set: bit remains 1.
- Assert reset_n=0 mid-debounce with the counter at 2: all outputs are 0 immediately without waiting for clk, and the FSM returns to IDLE.
- With PIO_EVENT_COUNT_EN defined: 3 separate captured edges make address 3 read 0x0003_0001. Writing 0x8000_0001 to address 3 then reads 0x0000_0001.

Source files
------------

// File: rtl/pio_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pio_ctrl_pkg
// Shared definitions for the switch-input PIO controller: Avalon register
// addresses, control-register bit positions, the controller FSM state type and
// the width of the optional event counter (present when PIO_EVENT_COUNT_EN is
// defined).
// -----------------------------------------------------------------------------
package pio_ctrl_pkg;

   localparam logic [1:0] ADDR_DATA = 2'd0;  // debounced inputs, read-only
   localparam logic [1:0] ADDR_MASK = 2'd1;  // interrupt mask
   localparam logic [1:0] ADDR_EDGE = 2'd2;  // sticky edge capture, write-1-clear
   localparam logic [1:0] ADDR_CTRL = 2'd3;  // EN / POL (+ event counter)

   localparam int CTRL_EN  = 0;
   localparam int CTRL_POL = 1;              // 0 = rising, 1 = falling

   localparam int EVT_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      RUN   = 2'd2
   } state_e;

endpackage : pio_ctrl_pkg

// File: rtl/pio_debounce_bit.sv
// -----------------------------------------------------------------------------
// pio_debounce_bit
// Debouncer for one synchronized switch bit. On a PRIME tick the level is
// loaded directly from the input. On a RUN tick a differing input advances a
// stability counter; after STABLE_CNT consecutive differing ticks the level
// toggles and a one-cycle rise/fall pulse is produced, aligned with the cycle
// in which the level register updates. Outside RUN the counter is cleared.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   tick_i         sample strobe from the prescaler
//   run_i          controller is in RUN
//   prime_i        controller is in PRIME
//   sync_i         synchronized switch bit
//   level_o        debounced level
//   rise_o/fall_o  pulse in the cycle the level changes 0->1 / 1->0
// -----------------------------------------------------------------------------
module pio_debounce_bit #(
   parameter int STABLE_CNT = 4
) (
   input  logic clk,
   input  logic reset_n,
   input  logic tick_i,
   input  logic run_i,
   input  logic prime_i,
   input  logic sync_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   logic [3:0] cnt_q, cnt_d;
   logic       level_q, level_d;
   logic       toggle;

   // NOTE: every signal assigned in always_comb gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      toggle  = 1'b0;
      if (prime_i && tick_i) begin
         level_d = sync_i;
         cnt_d   = '0;
      end else if (run_i) begin
         if (tick_i) begin
            if (sync_i != level_q) begin
               // This tick would make the count reach STABLE_CNT: accept.
               if (cnt_q == 4'(STABLE_CNT - 1)) begin
                  toggle  = 1'b1;
                  level_d = ~level_q;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 4'd1;
               end
            end else begin
               cnt_d = '0;  // glitch shorter than STABLE_CNT ticks rejected
            end
         end
      end else begin
         cnt_d = '0;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = toggle & ~level_q;
   assign fall_o  = toggle &  level_q;

endmodule : pio_debounce_bit

// File: rtl/pio_debounce_irq_ctrl.sv
// -----------------------------------------------------------------------------
// pio_debounce_irq_ctrl
// Switch-input PIO with debouncing, sticky edge capture and a maskable level
// interrupt, exposed as an Avalon-MM slave with read latency 1.
//
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   address[1:0]   0 debounced (RO), 1 mask, 2 edge_cap (W1C), 3 ctrl
//   read           read strobe (no side effects; readdata registered each cycle)
//   write          write strobe
//   writedata[31:0], readdata[31:0]
//   in_port        raw asynchronous switch inputs
//   irq            level interrupt = registered |(edge_cap & mask)
//
// Optional feature macro: PIO_EVENT_COUNT_EN
//   When defined, a 16-bit saturating counter of cycles in which any edge_cap
//   bit is newly set is readable at address 3 bits[31:16]; a write to address 3
//   with writedata[31]=1 clears it. When undefined those bits read 0.
// -----------------------------------------------------------------------------
module pio_debounce_irq_ctrl
   import pio_ctrl_pkg::*;
#(
   parameter int WIDTH      = 10,
   parameter int SAMPLE_DIV = 50000,
   parameter int STABLE_CNT = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       address,
   input  logic             read,
   input  logic             write,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   input  logic [WIDTH-1:0] in_port,
   output logic             irq
);

   localparam int            PW        = $clog2(SAMPLE_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SAMPLE_DIV - 1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [PW-1:0]    presc_q, presc_d;
   state_e           state_q, state_d;
   logic [WIDTH-1:0] deb, rise, fall, set;
   logic [WIDTH-1:0] edge_q, edge_d, mask_q, mask_d;
   logic [1:0]       ctrl_q, ctrl_d;
   logic [31:0]      readdata_q, readdata_d;
   logic             irq_q, irq_d;
   logic             en, pol, tick;
   logic             wr_mask, wr_edge, wr_ctrl;

   // read is a pure strobe and writedata is only partly decoded; folding them
   // here keeps them visibly consumed.
   logic unused_bus;
   assign unused_bus = ^{read, writedata};

   assign en   = ctrl_q[CTRL_EN];
   assign pol  = ctrl_q[CTRL_POL];
   assign tick = en && (presc_q == PRESC_MAX);

   assign presc_d = (!en || tick) ? '0 : presc_q + 1'b1;

   // ---------------- controller FSM ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (en) state_d = PRIME;
         PRIME:   if (!en) state_d = IDLE; else if (tick) state_d = RUN;
         RUN:     if (!en) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- per-bit debouncers ----------------
   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      pio_debounce_bit #(.STABLE_CNT(STABLE_CNT)) u_bit (
         .clk     (clk),
         .reset_n (reset_n),
         .tick_i  (tick),
         .run_i   (state_q == RUN),
         .prime_i (state_q == PRIME),
         .sync_i  (sync2_q[gi]),
         .level_o (deb[gi]),
         .rise_o  (rise[gi]),
         .fall_o  (fall[gi])
      );
   end

   // ---------------- registers ----------------
   assign wr_mask = write && (address == ADDR_MASK);
   assign wr_edge = write && (address == ADDR_EDGE);
   assign wr_ctrl = write && (address == ADDR_CTRL);
   assign set     = pol ? fall : rise;

`ifdef PIO_EVENT_COUNT_EN
   logic [EVT_CNT_W-1:0] evt_q, evt_d;

   // Counts cycles with at least one edge_cap bit going 0->1; clear wins.
   always_comb begin
      evt_d = evt_q;
      if (wr_ctrl && writedata[31]) begin
         evt_d = '0;
      end else if (|(set & ~edge_q) && (evt_q != '1)) begin
         evt_d = evt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) evt_q <= '0;
      else          evt_q <= evt_d;
   end
`endif

   always_comb begin
      // Set is OR-ed in after the clear so a same-cycle set survives.
      edge_d = (edge_q & ~(wr_edge ? writedata[WIDTH-1:0] : '0)) | set;
      mask_d = wr_mask ? writedata[WIDTH-1:0] : mask_q;
      ctrl_d = wr_ctrl ? writedata[1:0] : ctrl_q;
      irq_d  = |(edge_q & mask_q);

      readdata_d = '0;
      case (address)
         ADDR_DATA: readdata_d[WIDTH-1:0] = deb;
         ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
         ADDR_EDGE: readdata_d[WIDTH-1:0] = edge_q;
         ADDR_CTRL: begin
            readdata_d[1:0] = ctrl_q;
`ifdef PIO_EVENT_COUNT_EN
            readdata_d[31:16] = evt_q;
`endif
         end
         default:   readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         presc_q    <= '0;
         state_q    <= IDLE;
         edge_q     <= '0;
         mask_q     <= '0;
         ctrl_q     <= '0;
         readdata_q <= '0;
         irq_q      <= 1'b0;
      end else begin
         sync1_q    <= in_port;
         sync2_q    <= sync1_q;
         presc_q    <= presc_d;
         state_q    <= state_d;
         edge_q     <= edge_d;
         mask_q     <= mask_d;
         ctrl_q     <= ctrl_d;
         readdata_q <= readdata_d;
         irq_q      <= irq_d;
      end
   end

   assign readdata = readdata_q;
   assign irq      = irq_q;

endmodule : pio_debounce_irq_ctrl
